alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage directly upstream of the combinational 4-bit alu. Buffers incoming ALU
//  commands in a small FIFO, issues one at a time to alu through registered operand/op
//  lines, and captures the alu result and flags into an output register.
//  Maintains an accumulator for chained operations and exposes a valid/ready result port.
// PARAMETERS
//  WIDTH   4   data width; must match the alu operand width
//  DEPTH   4   command FIFO entries; power of 2, >= 2
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  in_valid      in   1      command valid
//  in_ready      out  1      FIFO can accept; = (fifo_count < DEPTH), from registered count only
//  in_op         in   3      000 ADD,001 SUB,010 AND,011 OR,100 SHL,101 SHR; 110/111 illegal
//  in_a          in   WIDTH  operand a (ignored when in_use_acc=1)
//  in_b          in   WIDTH  operand b
//  in_use_acc    in   1      1: operand a = accumulator value at issue time
//  alu_a/alu_b   out  WIDTH  registered operands to alu
//  alu_op        out  3      registered opcode to alu
//  alu_result    in   WIDTH  from alu
//  alu_carry, alu_zero, alu_negative, alu_overflow  in 1 each, from alu
//  out_valid     out  1      result valid
//  out_ready     in   1      consumer accepts
//  out_result    out  WIDTH  captured result
//  out_flags     out  4      {carry,zero,negative,overflow}
//  out_err       out  1      captured command had illegal opcode
//  acc           out  WIDTH  accumulator
//  fifo_count    out  $clog2(DEPTH)+1  FIFO occupancy
//  sticky_flags  out  4      OR-accumulated flags (see CONFIGURATION)
//  clr_sticky    in   1      clears sticky_flags
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE; asserting rst_n low mid-operation flushes
//   FIFO, drops out_valid, and loses any in-flight command.
//  Push on in_valid&&in_ready. Simultaneous push and pop: both happen; count unchanged.
//  Pointers wrap modulo DEPTH; push when full impossible (in_ready=0).
//  FSM IDLE: FIFO non-empty -> pop head into alu_a/alu_b/alu_op; go ISSUE.
//  FSM ISSUE: capture alu_result/flags into out_*; out_valid<=1; go HOLD.
//   Legal op: acc<=alu_result, out_err<=0.
//   Illegal op: out_result=0, out_flags=0, out_err=1, acc unchanged.
//  FSM HOLD: on out_valid&&out_ready edge: out_valid<=0; FIFO non-empty ? pop -> ISSUE : IDLE.
//   out_* held stable while out_valid&&!out_ready.
//  Latency: command pushed on edge N into empty stage -> out_valid high after edge N+2.
//  Peak throughput: 1 result per 2 cycles.
//  in_use_acc reads acc at pop edge; acc already includes the previous captured result.
//  Arithmetic is entirely in alu; this block never recomputes flags.
//  Shift ops: alu_b forwarded unchanged.
// CONFIGURATION
//  ALU_STICKY_FLAGS_EN defined:
//   sticky_flags |= out_flags on each ISSUE capture.
//   clr_sticky zeroes it; clear wins over a same-cycle capture.
//  Not defined: sticky_flags tied to 0; clr_sticky ignored.
// TESTING
//  1. ADD a=0101 b=0011 -> out_result 1000, out_flags 0011, out_valid 2 cycles after push
//  2. ADD a=0001 b=0001; then ADD use_acc b=0001 -> results 0010 then 0011; acc=0011
//  3. out_ready=0, push 6 cmds -> 5 accepted, fifo_count=4, in_ready=0;
//     out_ready=1 drains all in order.
//  4. op=111 a=0011 b=0001 -> out_result 0000, out_flags 0000, out_err 1, acc unchanged
//  5. Reset low while in ISSUE with 3 queued -> out_valid 0, fifo_count 0, acc 0 immediately
//  6. EN set: SUB 0000-0001 then ADD 0101+0011 -> sticky_flags 1011;
//     clr_sticky -> 0000

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: command FIFO, single-issue sequencer and result register in front of a combinational alu
// Optional sticky flag accumulation is enabled by defining ALU_STICKY_FLAGS_EN.
module alu_exec_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic                   in_use_acc,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_op,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_carry,
  input  logic                   alu_zero,
  input  logic                   alu_negative,
  input  logic                   alu_overflow,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic [3:0]             out_flags,
  output logic                   out_err,
  output logic [WIDTH-1:0]       acc,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [3:0]             sticky_flags,
  input  logic                   clr_sticky
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4 + 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t state, state_nx;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, fire, legal, head_use;
  logic [2:0] head_op;
  logic [WIDTH-1:0] head_a, head_b;
  logic [3:0] flags;
  assign in_ready = fifo_count < (AW + 1)'(DEPTH);
  assign push = in_valid && in_ready;
  assign fire = state == HOLD && out_valid && out_ready;
  assign pop = fifo_count != '0 && (state == IDLE || fire);
  assign legal = alu_op < 3'd6;
  assign flags = {alu_carry, alu_zero, alu_negative, alu_overflow};
  assign {head_use, head_op, head_a, head_b} = mem[rd_ptr];
  always_comb begin
    state_nx = (state == ISSUE) ? HOLD : pop ? ISSUE : fire ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_use_acc, in_op, in_a, in_b};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_err    <= 1'b0;
      acc        <= '0;
    end else begin
      state      <= state_nx;
      fifo_count <= fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      // acc is read here, so a chained command sees the result captured in the previous ISSUE
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        alu_a  <= head_use ? acc : head_a;
        alu_b  <= head_b;
        alu_op <= head_op;
      end
      if (fire) out_valid <= 1'b0;
      if (state == ISSUE) begin
        out_valid  <= 1'b1;
        out_result <= legal ? alu_result : '0;
        out_flags  <= legal ? flags : '0;
        out_err    <= !legal;
        if (legal) acc <= alu_result;
      end
    end
  end
`ifdef ALU_STICKY_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_flags <= '0;
    else if (clr_sticky) sticky_flags <= '0;
    else if (state == ISSUE) sticky_flags <= sticky_flags | (legal ? flags : 4'b0);
  end
`else
  logic unused_clr;
  assign unused_clr = clr_sticky;
  assign sticky_flags = '0;
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed table-driven bench with a behavioural 4-bit alu attached to the stage
module tb_alu_exec_stage;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_use_acc = 0, out_valid, out_ready = 1, out_err, clr_sticky = 0;
  logic [2:0] in_op = 0, alu_op;
  logic [3:0] in_a = 0, in_b = 0, alu_a, alu_b, alu_result, out_result, out_flags, acc, sticky_flags;
  logic alu_carry, alu_zero, alu_negative, alu_overflow;
  logic [2:0] fifo_count;
  int tests = 0, fails = 0;

  alu_exec_stage #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags), .out_err(out_err),
    .acc(acc), .fifo_count(fifo_count), .sticky_flags(sticky_flags), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  // reference alu; illegal opcodes produce deliberately nonzero junk
  logic [3:0] m_r;
  logic m_c, m_v;
  always_comb begin
    m_r = '0;
    m_c = 1'b0;
    m_v = 1'b0;
    case (alu_op)
      3'd0: begin
        {m_c, m_r} = {1'b0, alu_a} + {1'b0, alu_b};
        m_v = (alu_a[3] == alu_b[3]) && (m_r[3] != alu_a[3]);
      end
      3'd1: begin
        m_r = alu_a - alu_b;
        m_c = alu_a < alu_b;
        m_v = (alu_a[3] != alu_b[3]) && (m_r[3] != alu_a[3]);
      end
      3'd2: m_r = alu_a & alu_b;
      3'd3: m_r = alu_a | alu_b;
      3'd4: m_r = alu_a << alu_b;
      3'd5: m_r = alu_a >> alu_b;
      default: begin
        m_r = 4'hF;
        m_c = 1'b1;
        m_v = 1'b1;
      end
    endcase
  end
  assign alu_result = m_r;
  assign alu_carry = m_c;
  assign alu_zero = m_r == 4'h0;
  assign alu_negative = m_r[3];
  assign alu_overflow = m_v;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a, b;
    logic use_acc;
    logic [3:0] res, flags;
    logic err;
    logic [3:0] acc;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // single command into an idle stage with out_ready=1; checks 2-edge latency and captured values
  task automatic issue(input vec_t v, input string tag);
    in_op = v.op; in_a = v.a; in_b = v.b; in_use_acc = v.use_acc; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1 chk({tag, "_early"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_res"}, 32'(out_result), 32'(v.res));
    chk({tag, "_flags"}, 32'(out_flags), 32'(v.flags));
    chk({tag, "_err"}, 32'(out_err), 32'(v.err));
    chk({tag, "_acc"}, 32'(acc), 32'(v.acc));
    @(posedge clk); #1;
  endtask

  initial begin
    int acc_cnt, n, t;
    vecs[0]  = '{3'd0, 4'h5, 4'h3, 1'b0, 4'h8, 4'b0011, 1'b0, 4'h8};
    vecs[1]  = '{3'd0, 4'h1, 4'h1, 1'b0, 4'h2, 4'b0000, 1'b0, 4'h2};
    vecs[2]  = '{3'd0, 4'h9, 4'h1, 1'b1, 4'h3, 4'b0000, 1'b0, 4'h3};
    vecs[3]  = '{3'd1, 4'h0, 4'h1, 1'b0, 4'hF, 4'b1010, 1'b0, 4'hF};
    vecs[4]  = '{3'd2, 4'hC, 4'hA, 1'b0, 4'h8, 4'b0010, 1'b0, 4'h8};
    vecs[5]  = '{3'd3, 4'h0, 4'h0, 1'b0, 4'h0, 4'b0100, 1'b0, 4'h0};
    vecs[6]  = '{3'd4, 4'h3, 4'h1, 1'b0, 4'h6, 4'b0000, 1'b0, 4'h6};
    vecs[7]  = '{3'd5, 4'h8, 4'h2, 1'b0, 4'h2, 4'b0000, 1'b0, 4'h2};
    vecs[8]  = '{3'd7, 4'h3, 4'h1, 1'b0, 4'h0, 4'b0000, 1'b1, 4'h2};
    vecs[9]  = '{3'd6, 4'h3, 4'h1, 1'b0, 4'h0, 4'b0000, 1'b1, 4'h2};
    vecs[10] = '{3'd1, 4'h7, 4'h2, 1'b1, 4'h0, 4'b0100, 1'b0, 4'h0};
    vecs[11] = '{3'd0, 4'h7, 4'h1, 1'b0, 4'h8, 4'b0011, 1'b0, 4'h8};
    vecs[12] = '{3'd0, 4'hF, 4'h1, 1'b0, 4'h0, 4'b1100, 1'b0, 4'h0};
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_ready", 32'(in_ready), 1);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    foreach (vecs[i]) issue(vecs[i], $sformatf("v%0d", i));
    chk("idle_count", 32'(fifo_count), 0);

    // backpressure: six pushes, five fit (one in HOLD, four queued)
    out_ready = 0;
    acc_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      in_op = 3'd0; in_a = 4'(i); in_b = 4'h0; in_use_acc = 0; in_valid = 1;
      acc_cnt += int'(in_ready);
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("bp_accepted", 32'(acc_cnt), 5);
    chk("bp_count", 32'(fifo_count), 4);
    chk("bp_in_ready", 32'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold_valid", 32'(out_valid), 1);
    chk("bp_hold_res", 32'(out_result), 1);
    out_ready = 1;
    n = 0; t = 0;
    while (n < 5 && t < 50) begin
      if (out_valid) begin
        n++;
        chk($sformatf("drain%0d", n), 32'(out_result), 32'(n));
      end
      @(posedge clk); #1;
      t++;
    end
    chk("drain_n", 32'(n), 5);
    chk("drain_acc", 32'(acc), 5);

    // reset while ISSUE with three queued commands
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_op = 3'd0; in_a = 4'(i + 2); in_b = 4'h1; in_use_acc = 0; in_valid = 1;
      if (i == 4) out_ready = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("pre_rst_count", 32'(fifo_count), 3);
    chk("pre_rst_acc", 32'(acc), 3);
    rst_n = 0; #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_acc", 32'(acc), 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (4) @(posedge clk);
    #1 chk("post_rst_valid", 32'(out_valid), 0);

`ifdef ALU_STICKY_FLAGS_EN
    chk("sticky_rst", 32'(sticky_flags), 0);
    issue(vecs[3], "s_sub");
    issue(vecs[0], "s_add");
    chk("sticky_or", 32'(sticky_flags), 32'b1011);
    clr_sticky = 1;
    @(posedge clk); #1 clr_sticky = 0;
    chk("sticky_clr", 32'(sticky_flags), 0);
`else
    issue(vecs[3], "s_sub");
    chk("sticky_off", 32'(sticky_flags), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
